// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes between ID and WB and
// raises the decode-stage stall request. A PIPE_DEPTH-entry shift register
// mirrors EXE..WB, so the tracked state holds exactly when the pipeline is frozen.
// Optional build macro HAZARD_FWD_EN: EXE/MEM results are forwarded elsewhere,
// so only a load sitting in EXE (load-use) can cause a stall.
module hazard_scoreboard #(
   parameter int PIPE_DEPTH = 3,   // entry 0 = EXE ... PIPE_DEPTH-1 = WB, minimum 2
   parameter int REG_W      = 4,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  freeze,
   input  logic                  flush,
   input  logic                  id_wb_en,
   input  logic                  id_mem_r_en,
   input  logic [REG_W-1:0]      id_dest,
   input  logic [REG_W-1:0]      src1,
   input  logic [REG_W-1:0]      src2,
   input  logic                  Two_src,
   input  logic                  Ignore_Hazard,
   output logic                  hazard,
   output logic [(1<<REG_W)-1:0] busy_vec,
   output logic [CNT_W-1:0]      stall_cnt
);

   logic [PIPE_DEPTH-1:0]            vld_q, vld_d;
   logic [PIPE_DEPTH-1:0]            ld_q,  ld_d;
   logic [PIPE_DEPTH-1:0][REG_W-1:0] dst_q, dst_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic                             m1, m2;

   // Source match against in-flight producers. The WB entry is never checked:
   // the register file writes it in the first half of the cycle, before the ID read.
   always_comb begin
      m1 = 1'b0;
      m2 = 1'b0;
`ifdef HAZARD_FWD_EN
      m1 = vld_q[0] & ld_q[0] & (dst_q[0] == src1);
      m2 = vld_q[0] & ld_q[0] & (dst_q[0] == src2);
`else
      for (int i = 0; i < PIPE_DEPTH-1; i++) begin
         if (vld_q[i] && dst_q[i] == src1) m1 = 1'b1;
         if (vld_q[i] && dst_q[i] == src2) m2 = 1'b1;
      end
`endif
      hazard = ~Ignore_Hazard & (m1 | (Two_src & m2));
   end

   // Busy map covers every valid entry, WB included.
   always_comb begin
      busy_vec = '0;
      for (int i = 0; i < PIPE_DEPTH; i++)
         if (vld_q[i]) busy_vec[dst_q[i]] = 1'b1;
   end

   // Next state: shift on advance, bubble on stall or flush; freeze holds everything
   // (freeze wins over flush because the flush source re-asserts after the freeze).
   always_comb begin
      vld_d = vld_q;
      ld_d  = ld_q;
      dst_d = dst_q;
      cnt_d = cnt_q;
      if (!freeze) begin
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            ld_d[i]  = ld_q[i-1];
            dst_d[i] = dst_q[i-1];
         end
         vld_d[0] = id_wb_en & ~hazard & ~flush;
         ld_d[0]  = id_mem_r_en;
         dst_d[0] = id_dest;
         if (hazard && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State register; reset clears validity and the counter regardless of freeze/flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         ld_q  <= '0;
         dst_q <= '0;
         cnt_q <= '0;
      end else begin
         vld_q <= vld_d;
         ld_q  <= ld_d;
         dst_q <= dst_d;
         cnt_q <= cnt_d;
      end
   end

   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vectors with hand-computed expectations
// pushed into a queue; a negedge monitor pops and compares. A second instance with
// a 2-bit counter shares the stimulus to exercise counter saturation.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst, freeze, flush, id_wb_en, id_mem_r_en, Two_src, Ignore_Hazard;
   logic [3:0]  id_dest, src1, src2;
   logic        hazard, hazard_s;
   logic [15:0] busy_vec, busy_s;
   logic [15:0] stall_cnt;
   logic [1:0]  stall_cnt_s;

   typedef struct {
      int          id;
      logic        haz;
      logic [15:0] busy;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.PIPE_DEPTH(3), .REG_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
      .src1(src1), .src2(src2), .Two_src(Two_src), .Ignore_Hazard(Ignore_Hazard),
      .hazard(hazard), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
   );

   hazard_scoreboard #(.PIPE_DEPTH(3), .REG_W(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
      .src1(src1), .src2(src2), .Two_src(Two_src), .Ignore_Hazard(Ignore_Hazard),
      .hazard(hazard_s), .busy_vec(busy_s), .stall_cnt(stall_cnt_s)
   );

   // Monitor: compare the current cycle's outputs against the queued expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [1:0] sat;
         e   = exp_q.pop_front();
         sat = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
         checks += 5;
         if (hazard !== e.haz) begin
            errors++; $display("FAIL step%0d hazard got %b want %b", e.id, hazard, e.haz);
         end
         if (busy_vec !== e.busy) begin
            errors++; $display("FAIL step%0d busy_vec got %h want %h", e.id, busy_vec, e.busy);
         end
         if (stall_cnt !== e.cnt) begin
            errors++; $display("FAIL step%0d stall_cnt got %0d want %0d", e.id, stall_cnt, e.cnt);
         end
         if (hazard_s !== e.haz || busy_s !== e.busy) begin
            errors++; $display("FAIL step%0d sat_inst hazard/busy got %b/%h want %b/%h",
                               e.id, hazard_s, busy_s, e.haz, e.busy);
         end
         if (stall_cnt_s !== sat) begin
            errors++; $display("FAIL step%0d sat_cnt got %0d want %0d", e.id, stall_cnt_s, sat);
         end
      end
   end

   int step_no = 0;

   // Drive one cycle of inputs, optionally queue the expected outputs for that cycle.
   task automatic step(input logic r, fz, fl, wb, ld, input logic [3:0] dst, s1, s2,
                       input logic two, ign, chk, eh, input logic [15:0] eb, ec);
      exp_t e;
      rst = r; freeze = fz; flush = fl; id_wb_en = wb; id_mem_r_en = ld;
      id_dest = dst; src1 = s1; src2 = s2; Two_src = two; Ignore_Hazard = ign;
      step_no++;
      if (chk) begin
         e.id = step_no; e.haz = eh; e.busy = eb; e.cnt = ec;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      //    r fz fl wb ld dst s1 s2 two ign chk  haz busy     cnt
      // reset held with freeze and flush asserted
      step(1, 1, 1, 1, 0, 2, 0, 0, 0, 0, 0,  0, 16'h0000, 0);
      step(1, 1, 1, 1, 0, 2, 0, 0, 0, 0, 1,  0, 16'h0000, 0);
`ifdef HAZARD_FWD_EN
      // ALU producer of R1 forwards: no stall
      step(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1,  0, 16'h0000, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,  0, 16'h0002, 0);
      // load producer of R1: one-cycle load-use stall
      step(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1,  0, 16'h0002, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,  1, 16'h0002, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,  0, 16'h0002, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 16'h0002, 1);
`else
      // RAW on R2, back-to-back: two stall cycles, busy bit 2 for three cycles
      step(0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 1,  0, 16'h0000, 0);
      step(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1,  1, 16'h0004, 0);
      step(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1,  1, 16'h0004, 1);
      step(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1,  0, 16'h0004, 2);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 16'h0000, 2);
      // Two_src gating on R5
      step(0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 1,  0, 16'h0000, 2);
      step(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 1,  0, 16'h0020, 2);
      step(0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 1,  1, 16'h0020, 2);
      // Ignore_Hazard on R6; WB-stage producer (R5) is not a hazard
      step(0, 0, 0, 1, 0, 6, 0, 5, 1, 0, 1,  0, 16'h0020, 3);
      step(0, 0, 0, 0, 0, 0, 6, 0, 0, 1, 1,  0, 16'h0040, 3);
      step(0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 1,  1, 16'h0040, 3);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 16'h0040, 4);
      // freeze on R3 for 4 cycles (one with flush), then 2 advancing stall cycles
      step(0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 1,  0, 16'h0000, 4);
      step(0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 1,  1, 16'h0008, 4);
      step(0, 1, 1, 0, 0, 0, 3, 0, 0, 0, 1,  1, 16'h0008, 4);
      step(0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 1,  1, 16'h0008, 4);
      step(0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 1,  1, 16'h0008, 4);
      step(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1,  1, 16'h0008, 4);
      step(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1,  1, 16'h0008, 5);
      step(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1,  0, 16'h0008, 6);
      // flush drops R7
      step(0, 0, 1, 1, 0, 7, 0, 0, 0, 0, 1,  0, 16'h0000, 6);
      step(0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1,  0, 16'h0000, 6);
      // flush together with a stall: R9 never enters
      step(0, 0, 0, 1, 0, 8, 0, 0, 0, 0, 1,  0, 16'h0000, 6);
      step(0, 0, 1, 1, 0, 9, 8, 0, 0, 0, 1,  1, 16'h0100, 6);
      step(0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1,  0, 16'h0100, 7);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 16'h0100, 7);
      // reset mid-stall clears the stall immediately
      step(0, 0, 0, 1, 0, 10, 0, 0, 0, 0, 1, 0, 16'h0000, 7);
      step(1, 0, 0, 0, 0, 0, 10, 0, 0, 0, 1, 1, 16'h0400, 7);
      step(0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 1, 0, 16'h0000, 0);
`endif
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 16'h0000, 0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL drain queue left %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
